// File: rtl/ccff_pkg.sv
// Shared programming definitions for the configuration-chain loader.
// Holds the FSM state encoding and the default word and chain sizes.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_e;

    localparam int CCFF_WORD_W_DEF    = 32;
    localparam int CCFF_CHAIN_LEN_DEF = 4096;

endpackage

// File: rtl/ccff_frame_loader_rb_capture.sv
// Readback deserializer: packs ccff_tail samples into words, index 0 = first sample.
// Only instantiated when CCFF_READBACK_EN is defined.
module ccff_rb_capture
    import ccff_pkg::*;
#(
    parameter int WORD_W = CCFF_WORD_W_DEF
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              sample_en,
    input  logic              last_sample,
    input  logic              ccff_tail,
    output logic              rb_valid,
    output logic [0:WORD_W-1] rb_data
);
    localparam int WB_W = $clog2(WORD_W + 1);

    logic [0:WORD_W-1] cap_q, cap_d, cap_n;
    logic [WB_W-1:0]   cnt_q, cnt_d;
    logic              rb_valid_q, rb_valid_d;
    logic [0:WORD_W-1] rb_data_q, rb_data_d;

    always_comb begin
        cap_d      = cap_q;
        cnt_d      = cnt_q;
        rb_valid_d = 1'b0;
        rb_data_d  = rb_data_q;
        cap_n      = cap_q;
        if (sample_en) begin
            for (int i = 0; i < WORD_W; i++) begin
                if (int'(cnt_q) == i) begin
                    cap_n[i] = ccff_tail;
                end
            end
            // A flushed partial word is zero-padded because cap is cleared on every emit.
            if ((cnt_q == WB_W'(WORD_W - 1)) || last_sample) begin
                rb_valid_d = 1'b1;
                rb_data_d  = cap_n;
                cap_d      = '0;
                cnt_d      = '0;
            end else begin
                cap_d = cap_n;
                cnt_d = cnt_q + WB_W'(1);
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            cap_q      <= '0;
            cnt_q      <= '0;
            rb_valid_q <= 1'b0;
            rb_data_q  <= '0;
        end else begin
            cap_q      <= cap_d;
            cnt_q      <= cnt_d;
            rb_valid_q <= rb_valid_d;
            rb_data_q  <= rb_data_d;
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;

endmodule

// File: rtl/ccff_frame_loader.sv
// Serializes configuration words onto the fabric configuration chain (ccff_head/ccff_en).
// Readback capture of ccff_tail is built only when CCFF_READBACK_EN is defined.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start
// ST_LOAD  | word_ready high, waiting for the next word
// ST_SHIFT | a chain bit is on ccff_head with ccff_en high this cycle
// ST_DONE  | CHAIN_LEN bits shifted; start reloads
module ccff_frame_loader
    import ccff_pkg::*;
#(
    parameter int WORD_W    = CCFF_WORD_W_DEF,
    parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEF
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [0:WORD_W-1] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              rb_valid,
    output logic [0:WORD_W-1] rb_data
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

    ccff_state_e       state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [WB_W-1:0]   wbits_q, wbits_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              head_q, head_d;
    logic              en_q, en_d;
    logic [WORD_W-1:0] word_vec;
    logic              accept;
    logic              last_bit;

    always_comb begin
        word_vec = '0;
        for (int i = 0; i < WORD_W; i++) begin
            word_vec[i] = word_data[i];
        end
    end

    // rem_q and wbits_q count bits not yet placed on ccff_head, so the bit
    // currently shown is already excluded; a handshake drives bit 0 at once.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        wbits_d    = wbits_q;
        rem_d      = rem_q;
        head_d     = head_q;
        en_d       = 1'b0;
        word_ready = 1'b0;
        accept     = 1'b0;
        last_bit   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    rem_d   = CHAIN_LEN_C;
                end
            end
            ST_LOAD: begin
                word_ready = 1'b1;
                accept     = word_valid;
            end
            ST_SHIFT: begin
                if (wbits_q != '0) begin
                    head_d  = sreg_q[0];
                    sreg_d  = sreg_q >> 1;
                    en_d    = 1'b1;
                    wbits_d = wbits_q - WB_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                end else if (rem_q == '0) begin
                    state_d  = ST_DONE;
                    last_bit = 1'b1;
                end else begin
                    word_ready = 1'b1;
                    accept     = word_valid;
                    if (!word_valid) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d = ST_SHIFT;
            head_d  = word_vec[0];
            sreg_d  = word_vec >> 1;
            en_d    = 1'b1;
            rem_d   = rem_q - CNT_W'(1);
            // Final partial word: only the remaining low-index bits are ever driven.
            if (int'(rem_q) >= WORD_W) begin
                wbits_d = WB_W'(WORD_W - 1);
            end else begin
                wbits_d = WB_W'(rem_q - CNT_W'(1));
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            wbits_q <= '0;
            rem_q   <= CHAIN_LEN_C;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            wbits_q <= wbits_d;
            rem_q   <= rem_d;
            head_q  <= head_d;
            en_q    <= en_d;
        end
    end

    assign ccff_head = head_q;
    assign ccff_en   = en_q;
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);

`ifdef CCFF_READBACK_EN
    ccff_rb_capture #(
        .WORD_W(WORD_W)
    ) u_rb_capture (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .sample_en   (en_q),
        .last_sample (last_bit),
        .ccff_tail   (ccff_tail),
        .rb_valid    (rb_valid),
        .rb_data     (rb_data)
    );
`else
    logic unused_rb;
    assign unused_rb = ccff_tail ^ last_bit;
    assign rb_valid  = 1'b0;
    assign rb_data   = '0;
`endif

endmodule

// File: tb/tb_ccff_frame_loader.sv
// Directed bench for ccff_frame_loader: two WORD_W=4 loaders (CHAIN_LEN 8 and 6)
// plus a WORD_W=8 loader driving a chain model for readback.
module tb_ccff_frame_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // loaders 0 (CHAIN_LEN=8) and 1 (CHAIN_LEN=6), WORD_W=4
    logic [1:0] rst, st, wv, wr, hd, en, bz, dn, rv;
    logic [0:3] wd0, wd1, rd0, rd1;

    ccff_frame_loader #(.WORD_W(4), .CHAIN_LEN(8)) dut_a (
        .prog_clk(clk), .pReset(rst[0]), .start(st[0]), .word_valid(wv[0]),
        .word_data(wd0), .word_ready(wr[0]), .ccff_head(hd[0]), .ccff_en(en[0]),
        .ccff_tail(1'b0), .busy(bz[0]), .done(dn[0]), .rb_valid(rv[0]), .rb_data(rd0)
    );

    ccff_frame_loader #(.WORD_W(4), .CHAIN_LEN(6)) dut_b (
        .prog_clk(clk), .pReset(rst[1]), .start(st[1]), .word_valid(wv[1]),
        .word_data(wd1), .word_ready(wr[1]), .ccff_head(hd[1]), .ccff_en(en[1]),
        .ccff_tail(1'b0), .busy(bz[1]), .done(dn[1]), .rb_valid(rv[1]), .rb_data(rd1)
    );

    // readback loader, WORD_W=8, CHAIN_LEN=8, with an 8-flop chain preloaded to 0xC3
    localparam logic [7:0] CHAIN_INIT = 8'hC3;
    logic       rst2, st2, wv2, wr2, hd2, en2, tl2, bz2, dn2, rv2;
    logic [0:7] wd2, rd2;
    logic [7:0] chain = CHAIN_INIT;

    assign tl2 = chain[7];
    always @(posedge clk) if (en2) chain <= {chain[6:0], hd2};

    ccff_frame_loader #(.WORD_W(8), .CHAIN_LEN(8)) dut_c (
        .prog_clk(clk), .pReset(rst2), .start(st2), .word_valid(wv2),
        .word_data(wd2), .word_ready(wr2), .ccff_head(hd2), .ccff_en(en2),
        .ccff_tail(tl2), .busy(bz2), .done(dn2), .rb_valid(rv2), .rb_data(rd2)
    );

    // monitor: logs every ccff_en cycle and done/rb_valid events by cycle number
    int         cyc = 0;
    int         en_cnt [2] = '{0, 0};
    logic       bit_log [2][64];
    int         en_cyc [2][64];
    int         done_cyc [2] = '{-1, -1};
    logic [1:0] dn_prev = 2'b00;
    int         rb_cnt = 0;
    int         rb_cyc = -1;
    int         dn2_cyc = -1;
    logic       dn2_prev = 1'b0;
    logic [0:7] rb_cap = '0;

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (en[s] === 1'b1) begin
                if (en_cnt[s] < 64) begin
                    bit_log[s][en_cnt[s]] = hd[s];
                    en_cyc[s][en_cnt[s]]  = cyc;
                end
                en_cnt[s]++;
            end
            if (dn[s] === 1'b1 && dn_prev[s] !== 1'b1) done_cyc[s] = cyc;
        end
        dn_prev = dn;
        if (rv2 === 1'b1) begin
            rb_cnt++;
            rb_cyc = cyc;
            rb_cap = rd2;
        end
        if (dn2 === 1'b1 && dn2_prev !== 1'b1) dn2_cyc = cyc;
        dn2_prev = dn2;
        cyc++;
    end

    task automatic pulse_start(input int s);
        st[s] = 1'b1;
        @(posedge clk); #1;
        st[s] = 1'b0;
    endtask

    // word value v places v[i] at word_data index i, so index 0 (shifted first) is v's LSB
    task automatic send(input int s, input logic [3:0] v);
        bit ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (s == 0) wd0[i] = v[i];
            else        wd1[i] = v[i];
        end
        wv[s] = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (wr[s] === 1'b1) ok = 1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        wv[s] = 1'b0;
    endtask

    task automatic wait_done(input int s);
        bit ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (dn[s] === 1'b1) ok = 1;
        end
        if (!ok) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    // exp[k] is the k-th bit expected on ccff_head; gap = idle cycles between the words
    task automatic check_load(input int s, input int base, input int n, input logic [7:0] exp,
                              input int gap, input string tag);
        chk({tag, "_en_count"}, en_cnt[s] - base, n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_bit%0d", tag, k), {31'd0, bit_log[s][base+k]}, {31'd0, exp[k]});
        end
        chk({tag, "_span"}, en_cyc[s][base+n-1] - en_cyc[s][base], n - 1 + gap);
        chk({tag, "_done_cyc"}, done_cyc[s], en_cyc[s][base+n-1] + 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        logic [0:7] rb_exp;
        bit ok;

        rst = 2'b11; st = '0; wv = '0; wd0 = '0; wd1 = '0;
        rst2 = 1'b1; st2 = 1'b0; wv2 = 1'b0; wd2 = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_ready", {31'd0, wr[0]}, 0);
        chk("rst_head",  {31'd0, hd[0]}, 0);
        chk("rst_en",    {31'd0, en[0]}, 0);
        chk("rst_busy",  {31'd0, bz[0]}, 0);
        chk("rst_done",  {31'd0, dn[0]}, 0);
        chk("rst_rbv",   {31'd0, rv2}, 0);
        chk("rst_rbd",   {24'd0, rd2}, 0);
        rst = 2'b00; rst2 = 1'b0;
        @(posedge clk); #1;

        // A: 0xA then 0x5 back-to-back -> 0,1,0,1,1,0,1,0
        base = en_cnt[0];
        pulse_start(0);
        chk("a_ready_after_start", {31'd0, wr[0]}, 1);
        chk("a_busy_after_start",  {31'd0, bz[0]}, 1);
        send(0, 4'hA);
        send(0, 4'h5);
        wait_done(0);
        check_load(0, base, 8, 8'b0101_1010, 0, "a");
        chk("a_busy_in_done", {31'd0, bz[0]}, 0);

        // B: CHAIN_LEN=6, 0xF then 0x3 -> six ones, high bits of 0x3 never driven
        base = en_cnt[1];
        pulse_start(1);
        send(1, 4'hF);
        send(1, 4'h3);
        wait_done(1);
        check_load(1, base, 6, 8'b0011_1111, 0, "b");

        // C: 0x3, valid dropped 3 cycles, then 0xC -> 1,1,0,0,0,0,1,1 from DONE
        base = en_cnt[0];
        pulse_start(0);
        send(0, 4'h3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("c_gap_ready", {31'd0, wr[0]}, 1);
        chk("c_gap_en",    {31'd0, en[0]}, 0);
        repeat (2) @(posedge clk); #1;
        send(0, 4'hC);
        wait_done(0);
        check_load(0, base, 8, 8'b1100_0011, 3, "c");

        // D: reset after 3 bits, then a full restart with 0x6, 0x9 -> 0,1,1,0,1,0,0,1
        base = en_cnt[0];
        pulse_start(0);
        send(0, 4'hF);
        repeat (2) @(posedge clk); #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk("d_rst_en",    {31'd0, en[0]}, 0);
        chk("d_rst_busy",  {31'd0, bz[0]}, 0);
        chk("d_rst_ready", {31'd0, wr[0]}, 0);
        @(negedge clk); #1;
        chk("d_bits_before_rst", en_cnt[0] - base, 3);
        base = en_cnt[0];
        pulse_start(0);
        send(0, 4'h6);
        send(0, 4'h9);
        wait_done(0);
        check_load(0, base, 8, 8'b1001_0110, 0, "d");

        // E: start pulsed mid-shift is ignored; 0x1, 0x8 -> 1,0,0,0,0,0,0,1
        base = en_cnt[0];
        pulse_start(0);
        send(0, 4'h1);
        @(posedge clk); #1;
        pulse_start(0);
        chk("e_busy", {31'd0, bz[0]}, 1);
        send(0, 4'h8);
        wait_done(0);
        check_load(0, base, 8, 8'b1000_0001, 0, "e");

        // F: readback loader shifts one word while the chain model returns 0xC3
        st2 = 1'b1;
        @(posedge clk); #1;
        st2 = 1'b0;
        wd2 = 8'h5A;
        wv2 = 1'b1;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (wr2 === 1'b1) ok = 1;
        end
        if (!ok) chk("f_send_timeout", 0, 1);
        @(posedge clk); #1;
        wv2 = 1'b0;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (dn2 === 1'b1) ok = 1;
        end
        if (!ok) chk("f_done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("f_chain_loaded", {24'd0, chain}, 32'h5A);
`ifdef CCFF_READBACK_EN
        for (int i = 0; i < 8; i++) rb_exp[i] = CHAIN_INIT[7-i];
        chk("f_rb_pulses", rb_cnt, 1);
        chk("f_rb_data",   {24'd0, rb_cap}, {24'd0, rb_exp});
        chk("f_rb_cycle",  rb_cyc, dn2_cyc);
`else
        rb_exp = '0;
        chk("f_rb_pulses", rb_cnt, 0);
        chk("f_rb_data",   {24'd0, rd2}, {24'd0, rb_exp});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
